// File: rtl/mem_wb_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_pkg
// Shared definitions for the MEM/WB pipeline register:
//   - bit positions of the write-back control bundle
//   - the WB bundle type
//   - bit bounds of the destination-register (rd) field in an instruction
// ---------------------------------------------------------------------------
package mem_wb_pkg;

    // Bit positions inside the WB control bundle.
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    // Write-back control bundle coming from the control unit.
    typedef logic [1:0] wb_bundle_t;

    // rd field bounds in a RISC-V instruction word.
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 7;

endpackage : mem_wb_pkg

// File: rtl/mem_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// Parameterised pipeline register with asynchronous active-low reset.
// Loads i_d on every rising clock edge while reset is high; clears to 0
// immediately when reset falls and holds 0 while reset stays low.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset (0 = reset)
//   i_d    in   width  data to capture
//   o_q    out  width  registered data
// ---------------------------------------------------------------------------
module pipe_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg

// File: rtl/mem_wb_module.sv
// ---------------------------------------------------------------------------
// mem_wb_module
// MEM/WB pipeline register of the pipelined RISC-V core. Captures the
// write-back control bits, memory read data, ALU result and instruction
// word every cycle and presents them to the write-back stage. The reset
// state (all zeros) is a bubble: regWrite = 0.
//
// Ports:
//   clk             in   1      rising-edge clock
//   reset           in   1      asynchronous active-low reset (0 = reset)
//   WB              in   2      bit 0 = regWrite, bit 1 = memToReg
//   readData        in   width  data read from memory
//   aluResult       in   width  ALU result from EX/MEM
//   instruction     in   width  instruction word
//   regWriteOut     out  1      registered WB[0]
//   memToRegOut     out  1      registered WB[1]
//   readDataOut     out  width  registered readData
//   aluResultOut    out  width  registered aluResult
//   instructionOut  out  width  registered instruction
//
// Optional feature (macro MEM_WB_WB_FWD_EN):
//   wbDataOut       out  width  memToRegOut ? readDataOut : aluResultOut
//   rdOut           out  5      instructionOut[11:7]
// ---------------------------------------------------------------------------
module mem_wb_module
    import mem_wb_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  wb_bundle_t       WB,
    input  logic [width-1:0] readData,
    input  logic [width-1:0] aluResult,
    input  logic [width-1:0] instruction,
    output logic             regWriteOut,
    output logic             memToRegOut,
    output logic [width-1:0] readDataOut,
    output logic [width-1:0] aluResultOut,
    output logic [width-1:0] instructionOut
`ifdef MEM_WB_WB_FWD_EN
    ,
    output logic [width-1:0] wbDataOut,
    output logic [4:0]       rdOut
`endif
);

    logic w_regwrite_d;
    logic w_memtoreg_d;
    logic w_regwrite_q;
    logic w_memtoreg_q;

    // Fixed bit mapping; the bundle is never decoded or reordered.
    assign w_regwrite_d = WB[WB_REGWRITE];
    assign w_memtoreg_d = WB[WB_MEMTOREG];

    pipe_reg #(.width(1)) u_regwrite (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_regwrite_d),
        .o_q   (w_regwrite_q)
    );

    pipe_reg #(.width(1)) u_memtoreg (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_memtoreg_d),
        .o_q   (w_memtoreg_q)
    );

    pipe_reg #(.width(width)) u_readdata (
        .clk   (clk),
        .reset (reset),
        .i_d   (readData),
        .o_q   (readDataOut)
    );

    pipe_reg #(.width(width)) u_aluresult (
        .clk   (clk),
        .reset (reset),
        .i_d   (aluResult),
        .o_q   (aluResultOut)
    );

    pipe_reg #(.width(width)) u_instruction (
        .clk   (clk),
        .reset (reset),
        .i_d   (instruction),
        .o_q   (instructionOut)
    );

    assign regWriteOut = w_regwrite_q;
    assign memToRegOut = w_memtoreg_q;

`ifdef MEM_WB_WB_FWD_EN
    // Both derive only from registered fields, so they read 0 in reset
    // without extra gating.
    assign wbDataOut = w_memtoreg_q ? readDataOut : aluResultOut;
    assign rdOut     = instructionOut[RD_MSB:RD_LSB];
`endif

endmodule : mem_wb_module

// File: tb/tb_mem_wb_module.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_module
// Scoreboard bench for mem_wb_module: expected output vectors are queued
// when stimulus is applied and popped/compared after the capturing edge.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mem_wb_module;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  WB = 2'b00;
    logic [31:0] readData = '0;
    logic [31:0] aluResult = '0;
    logic [31:0] instruction = '0;
    logic        regWriteOut;
    logic        memToRegOut;
    logic [31:0] readDataOut;
    logic [31:0] aluResultOut;
    logic [31:0] instructionOut;
`ifdef MEM_WB_WB_FWD_EN
    logic [31:0] wbDataOut;
    logic [4:0]  rdOut;
`endif

    mem_wb_module #(.width(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .WB             (WB),
        .readData       (readData),
        .aluResult      (aluResult),
        .instruction    (instruction),
        .regWriteOut    (regWriteOut),
        .memToRegOut    (memToRegOut),
        .readDataOut    (readDataOut),
        .aluResultOut   (aluResultOut),
        .instructionOut (instructionOut)
`ifdef MEM_WB_WB_FWD_EN
        ,
        .wbDataOut      (wbDataOut),
        .rdOut          (rdOut)
`endif
    );

    always #5 clk = ~clk;

    // Observed vector: {regWriteOut, memToRegOut, readData, alu, instr}
    logic [97:0] obs;
    assign obs = {regWriteOut, memToRegOut, readDataOut, aluResultOut, instructionOut};

    logic [97:0] sb_q[$];
    int total = 0;
    int bad   = 0;

    // Apply inputs and queue the vector expected after the next edge.
    task automatic drive(input logic [1:0] wb, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [31:0] ins);
        WB          = wb;
        readData    = rd;
        aluResult   = alu;
        instruction = ins;
        sb_q.push_back({wb[0], wb[1], rd, alu, ins});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [97:0] exp_v;
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            WB          = 2'($urandom);
            readData    = $urandom;
            aluResult   = $urandom;
            instruction = $urandom;
            sb_q.push_back('0);
            tick();
            exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, exp_v);
            end else $display("txn reset_hold[%0d] obs=%h", i, obs);
        end
        // Release between edges with inputs held: still 0 until the edge.
        reset = 1'b1;
        #2;
        total++;
        if (obs !== 98'b0) begin
            bad++;
            $display("FAIL reset_release_pre: got %h want 0", obs);
        end else $display("txn reset_release_pre obs=%h", obs);
        sb_q.push_back({WB[0], WB[1], readData, aluResult, instruction});
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_release_load: got %h want %h", obs, exp_v);
        end else $display("txn reset_release_load obs=%h", obs);
    endtask

    task automatic test_hold();
        logic [97:0] exp_v;
        drive(2'b11, 32'h1, 32'h2, 32'h3);
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL hold_load: got %h want %h", obs, exp_v);
        end else $display("txn hold_load obs=%h", obs);
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(exp_v);
            tick();
            exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold_stable[%0d]: got %h want %h", i, obs, exp_v);
            end else $display("txn hold_stable[%0d] obs=%h", i, obs);
        end
    endtask

    task automatic test_wb_map();
        logic [1:0] pat[2];
        logic [97:0] exp_v;
        pat[0] = 2'b01;
        pat[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            drive(pat[i], 32'h100 + i, 32'h200 + i, 32'h300 + i);
            tick();
            exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL wb_map[%0d]: got rw=%b m2r=%b want rw=%b m2r=%b",
                         i, regWriteOut, memToRegOut, exp_v[97], exp_v[96]);
            end else $display("txn wb_map[%0d] rw=%b m2r=%b", i, regWriteOut, memToRegOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [97:0] exp_v;
        for (int i = 0; i < 10; i++) begin
            drive(2'($urandom), $urandom, $urandom, $urandom);
            tick();
            exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL b2b[%0d]: got %h want %h", i, obs, exp_v);
            end else $display("txn b2b[%0d] obs=%h", i, obs);
        end
    endtask

    task automatic test_async_reset();
        logic [97:0] exp_v;
        drive(2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL async_load: got %h want %h", obs, exp_v);
        end else $display("txn async_load obs=%h", obs);
        // Mid-cycle assertion: outputs must clear before the next edge.
        #4 reset = 1'b0;
        #1;
        total++;
        if (obs !== 98'b0) begin
            bad++;
            $display("FAIL async_clear: got %h want 0", obs);
        end else $display("txn async_clear obs=%h", obs);
        sb_q.push_back('0);
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL async_edge_ignored: got %h want %h", obs, exp_v);
        end else $display("txn async_edge_ignored obs=%h", obs);
        reset = 1'b1;
        sb_q.push_back({WB[0], WB[1], readData, aluResult, instruction});
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL async_reload: got %h want %h", obs, exp_v);
        end else $display("txn async_reload obs=%h", obs);
    endtask

`ifdef MEM_WB_WB_FWD_EN
    task automatic test_fwd();
        logic [97:0] exp_v;
        drive(2'b11, 32'd5, 32'd9, 32'h00A00593);
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v || wbDataOut !== 32'd5 || rdOut !== 5'd11) begin
            bad++;
            $display("FAIL fwd_mem: got wb=%h rd=%0d want wb=5 rd=11", wbDataOut, rdOut);
        end else $display("txn fwd_mem wb=%h rd=%0d", wbDataOut, rdOut);
        drive(2'b01, 32'd5, 32'd9, 32'h00A00593);
        tick();
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        total++;
        if (obs !== exp_v || wbDataOut !== 32'd9 || rdOut !== 5'd11) begin
            bad++;
            $display("FAIL fwd_alu: got wb=%h rd=%0d want wb=9 rd=11", wbDataOut, rdOut);
        end else $display("txn fwd_alu wb=%h rd=%0d", wbDataOut, rdOut);
        #4 reset = 1'b0;
        #1;
        total++;
        if (wbDataOut !== 32'd0 || rdOut !== 5'd0) begin
            bad++;
            $display("FAIL fwd_reset: got wb=%h rd=%0d want 0", wbDataOut, rdOut);
        end else $display("txn fwd_reset wb=%h rd=%0d", wbDataOut, rdOut);
        tick();
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_wb_map();
        test_back_to_back();
        test_async_reset();
`ifdef MEM_WB_WB_FWD_EN
        test_fwd();
`endif
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_wb_module
